// File: rtl/qam_demapper_pipe.sv
// Two-stage hard-decision QAM demapper (BPSK/QPSK/16QAM/64QAM) with amplitude-scaled thresholds.
// Latency 2 cycles; whole pipe stalls while out_valid & ~out_ready. Optional ovr_count via DEMAP_OVR_CNT_EN.
module qam_demapper_pipe #(
    parameter int DATA_W        = 16,
    parameter int IDX_W         = 12,
    parameter int DEFAULT_SCALE = 1024
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [1:0]               cfg_qam_type,
    input  logic [DATA_W-2:0]        cfg_scale,
    input  logic signed [DATA_W-1:0] in_inphase,
    input  logic signed [DATA_W-1:0] in_quadrat,
    input  logic                     in_sof,
    input  logic                     in_last,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [5:0]               out_symbol,
    output logic [2:0]               out_nbits,
    output logic [IDX_W-1:0]         out_sym_idx,
    output logic                     out_last,
    output logic                     out_valid,
    input  logic                     out_ready
`ifdef DEMAP_OVR_CNT_EN
    ,
    output logic [15:0]              ovr_count
`endif
);
    localparam int MW = DATA_W - 1;
    localparam int CW = DATA_W + 2;

    typedef enum logic [1:0] {
        MODE_BPSK  = 2'b00,
        MODE_QPSK  = 2'b01,
        MODE_16QAM = 2'b10,
        MODE_64QAM = 2'b11
    } mode_e;

    logic             en;
    logic             accept;
    mode_e            mode_q, mode_d;
    logic [MW-1:0]    scale_q, scale_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [MW-1:0]    mag_i, mag_q;

    logic             s1_vld_q, s1_sign_i_q, s1_sign_q_q, s1_last_q;
    logic [MW-1:0]    s1_mag_i_q, s1_mag_q_q, s1_scale_q;
    mode_e            s1_mode_q;
    logic [IDX_W-1:0] s1_idx_q;

    logic             out_vld_q, out_last_q;
    logic [5:0]       sym_q, sym_d;
    logic [2:0]       nbits_q, nbits_d;
    logic [IDX_W-1:0] out_idx_q;

    logic [CW-1:0]    i3, q3, i7, q7, s2, s4, s6;

    // Two's-complement negation of the most-negative sample overflows; clamp it.
    function automatic logic [MW-1:0] mag_sat(input logic signed [DATA_W-1:0] x);
        logic [DATA_W-1:0] neg;
        neg = ~x + 1'b1;
        if (!x[DATA_W-1])
            return x[MW-1:0];
        else if (neg[DATA_W-1])
            return {MW{1'b1}};
        else
            return neg[MW-1:0];
    endfunction

    assign en       = out_ready | ~out_vld_q;
    assign in_ready = en;
    assign accept   = in_valid & en;

    always_comb begin
        mode_d  = in_sof ? mode_e'(cfg_qam_type) : mode_q;
        scale_d = in_sof ? cfg_scale : scale_q;
        idx_d   = in_sof ? '0 : idx_q;
        mag_i   = mag_sat(in_inphase);
        mag_q   = mag_sat(in_quadrat);
    end

    always_comb begin
        i3 = CW'(s1_mag_i_q) * CW'(3);
        q3 = CW'(s1_mag_q_q) * CW'(3);
        i7 = CW'(s1_mag_i_q) * CW'(7);
        q7 = CW'(s1_mag_q_q) * CW'(7);
        s2 = CW'(s1_scale_q) << 1;
        s4 = CW'(s1_scale_q) << 2;
        s6 = s2 + s4;
        sym_d   = '0;
        nbits_d = 3'd1;
        case (s1_mode_q)
            MODE_BPSK: begin
                sym_d[0] = ~s1_sign_i_q;
                nbits_d  = 3'd1;
            end
            MODE_QPSK: begin
                sym_d[0] = ~s1_sign_i_q;
                sym_d[1] = ~s1_sign_q_q;
                nbits_d  = 3'd2;
            end
            MODE_16QAM: begin
                sym_d[0] = ~s1_sign_i_q;
                sym_d[1] = i3 < s2;
                sym_d[2] = ~s1_sign_q_q;
                sym_d[3] = q3 < s2;
                nbits_d  = 3'd4;
            end
            default: begin
                sym_d[0] = ~s1_sign_i_q;
                sym_d[1] = i7 < s4;
                sym_d[2] = (i7 > s2) & (i7 < s6);
                sym_d[3] = ~s1_sign_q_q;
                sym_d[4] = q7 < s4;
                sym_d[5] = (q7 > s2) & (q7 < s6);
                nbits_d  = 3'd6;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q      <= MODE_BPSK;
            scale_q     <= MW'(DEFAULT_SCALE);
            idx_q       <= '0;
            s1_vld_q    <= 1'b0;
            s1_sign_i_q <= 1'b0;
            s1_sign_q_q <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_mag_i_q  <= '0;
            s1_mag_q_q  <= '0;
            s1_scale_q  <= '0;
            s1_mode_q   <= MODE_BPSK;
            s1_idx_q    <= '0;
            out_vld_q   <= 1'b0;
            out_last_q  <= 1'b0;
            sym_q       <= '0;
            nbits_q     <= 3'd1;
            out_idx_q   <= '0;
        end else begin
            if (accept) begin
                mode_q      <= mode_d;
                scale_q     <= scale_d;
                idx_q       <= idx_d + 1'b1;
                s1_sign_i_q <= in_inphase[DATA_W-1];
                s1_sign_q_q <= in_quadrat[DATA_W-1];
                s1_mag_i_q  <= mag_i;
                s1_mag_q_q  <= mag_q;
                s1_mode_q   <= mode_d;
                s1_scale_q  <= scale_d;
                s1_last_q   <= in_last;
                s1_idx_q    <= idx_d;
            end
            if (en) begin
                s1_vld_q  <= in_valid;
                out_vld_q <= s1_vld_q;
                if (s1_vld_q) begin
                    sym_q      <= sym_d;
                    nbits_q    <= nbits_d;
                    out_idx_q  <= s1_idx_q;
                    out_last_q <= s1_last_q;
                end
            end
        end
    end

`ifdef DEMAP_OVR_CNT_EN
    logic [15:0] ovr_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            ovr_q <= '0;
        else if (accept && ((mag_i > scale_d) || (mag_q > scale_d)) && (ovr_q != 16'hFFFF))
            ovr_q <= ovr_q + 1'b1;
    end

    assign ovr_count = ovr_q;
`endif

    assign out_valid   = out_vld_q;
    assign out_symbol  = sym_q;
    assign out_nbits   = nbits_q;
    assign out_sym_idx = out_idx_q;
    assign out_last    = out_last_q;
endmodule

// File: tb/tb_qam_demapper_pipe.sv
// Randomised and directed bench for qam_demapper_pipe against a behavioural decision model.
// Index width is reduced to 3 so wrap-around shows up in short frames.
module tb_qam_demapper_pipe;
    localparam int DATA_W = 16;
    localparam int IDX_W  = 3;

    logic                     clk = 1'b0;
    logic                     reset;
    logic [1:0]               cfg_qam_type;
    logic [DATA_W-2:0]        cfg_scale;
    logic signed [DATA_W-1:0] in_inphase, in_quadrat;
    logic                     in_sof, in_last, in_valid, in_ready;
    logic [5:0]               out_symbol;
    logic [2:0]               out_nbits;
    logic [IDX_W-1:0]         out_sym_idx;
    logic                     out_last, out_valid, out_ready;
`ifdef DEMAP_OVR_CNT_EN
    logic [15:0]              ovr_count;
`endif

    qam_demapper_pipe #(.DATA_W(DATA_W), .IDX_W(IDX_W), .DEFAULT_SCALE(1024)) dut (
        .clk(clk), .reset(reset),
        .cfg_qam_type(cfg_qam_type), .cfg_scale(cfg_scale),
        .in_inphase(in_inphase), .in_quadrat(in_quadrat),
        .in_sof(in_sof), .in_last(in_last), .in_valid(in_valid), .in_ready(in_ready),
        .out_symbol(out_symbol), .out_nbits(out_nbits), .out_sym_idx(out_sym_idx),
        .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready)
`ifdef DEMAP_OVR_CNT_EN
        , .ovr_count(ovr_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0]       sym;
        logic [2:0]       nb;
        logic [IDX_W-1:0] idx;
        logic             last;
    } beat_t;

    beat_t expq[$];
    beat_t obsq[$];
    int total = 0;
    int bad   = 0;
    int m_mode = 0, m_scale = 1024, m_idx = 0, m_ovr = 0, acc_cnt = 0;

    // Reference: decide bits from the frame's mode/scale using plain integer arithmetic.
    task automatic model_push();
        int ai, aq, s;
        beat_t b;
        if (in_sof) begin
            m_mode  = int'(cfg_qam_type);
            m_scale = int'(cfg_scale);
            m_idx   = 0;
        end
        ai = (in_inphase < 0) ? -int'(in_inphase) : int'(in_inphase);
        aq = (in_quadrat < 0) ? -int'(in_quadrat) : int'(in_quadrat);
        if (ai > 32767) ai = 32767;
        if (aq > 32767) aq = 32767;
        s = m_scale;
        b.sym = '0;
        b.sym[0] = (in_inphase >= 0);
        case (m_mode)
            0: b.nb = 3'd1;
            1: begin b.nb = 3'd2; b.sym[1] = (in_quadrat >= 0); end
            2: begin
                b.nb = 3'd4;
                b.sym[1] = (3 * ai < 2 * s);
                b.sym[2] = (in_quadrat >= 0);
                b.sym[3] = (3 * aq < 2 * s);
            end
            default: begin
                b.nb = 3'd6;
                b.sym[1] = (7 * ai < 4 * s);
                b.sym[2] = (7 * ai > 2 * s) && (7 * ai < 6 * s);
                b.sym[3] = (in_quadrat >= 0);
                b.sym[4] = (7 * aq < 4 * s);
                b.sym[5] = (7 * aq > 2 * s) && (7 * aq < 6 * s);
            end
        endcase
        b.idx  = IDX_W'(m_idx);
        b.last = in_last;
        m_idx  = (m_idx + 1) % (1 << IDX_W);
        if ((ai > s || aq > s) && m_ovr < 65535) m_ovr++;
        expq.push_back(b);
        acc_cnt++;
    endtask

    // Called at a negedge with inputs already set; records the handshakes of the coming posedge.
    task automatic tick();
        beat_t o;
        #1;
        if (out_valid && out_ready) begin
            o.sym = out_symbol; o.nb = out_nbits; o.idx = out_sym_idx; o.last = out_last;
            obsq.push_back(o);
        end
        if (in_valid && in_ready) model_push();
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic sof, input logic last, input logic [1:0] q,
                         input int sc, input int i, input int qq);
        in_valid = v; in_sof = sof; in_last = last; cfg_qam_type = q;
        cfg_scale = (DATA_W-1)'(sc); in_inphase = DATA_W'(i); in_quadrat = DATA_W'(qq);
    endtask

    task automatic drain();
        in_valid = 1'b0; in_sof = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 20 && obsq.size() < expq.size(); k++) tick();
        repeat (2) tick();
    endtask

    function automatic int pick_sample(input int sc);
        int v;
        if ($urandom_range(0, 9) < 6) return int'($urandom_range(0, 65535)) - 32768;
        case ($urandom_range(0, 7))
            0: v = 2 * sc / 3;
            1: v = 2 * sc / 7;
            2: v = 4 * sc / 7;
            3: v = 6 * sc / 7;
            4: v = sc;
            5: v = 0;
            6: v = 32767;
            default: return -32768;
        endcase
        return ($urandom_range(0, 1) == 1) ? -v : v;
    endfunction

    task automatic test_reset();
        reset = 1'b1; out_ready = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 2'b00, 0, 0, 0);
        repeat (2) @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", out_valid); end
        total++; if (out_symbol !== 6'h00) begin bad++; $display("FAIL reset_symbol got=%h want=00", out_symbol); end
        total++; if (out_nbits !== 3'd1) begin bad++; $display("FAIL reset_nbits got=%0d want=1", out_nbits); end
        total++; if (out_sym_idx !== '0) begin bad++; $display("FAIL reset_idx got=%0d want=0", out_sym_idx); end
        total++; if (out_last !== 1'b0) begin bad++; $display("FAIL reset_last got=%b want=0", out_last); end
        reset = 1'b0;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        @(negedge clk);
    endtask

    task automatic test_qam64_latency();
        drive(1'b1, 1'b1, 1'b0, 2'b11, 1024, 300, -700);
        tick();
        drive(1'b0, 1'b0, 1'b0, 2'b11, 1024, 0, 0);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL lat_early got=%b want=0", out_valid); end
        tick();
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL lat_valid got=%b want=1", out_valid); end
        total++; if (out_symbol !== 6'h27) begin bad++; $display("FAIL qam64_symbol got=%h want=27", out_symbol); end
        total++; if (out_nbits !== 3'd6) begin bad++; $display("FAIL qam64_nbits got=%0d want=6", out_nbits); end
        total++; if (out_sym_idx !== 3'd0) begin bad++; $display("FAIL qam64_idx got=%0d want=0", out_sym_idx); end
        drain();
        expq.delete(); obsq.delete();
    endtask

    task automatic test_qam16_cfg_hold();
        drive(1'b1, 1'b1, 1'b0, 2'b10, 900, 700, -200);
        tick();
        drive(1'b1, 1'b0, 1'b0, 2'b11, 100, -100, 1000);
        tick();
        drain();
        total++;
        if (obsq.size() !== 2) begin
            bad++; $display("FAIL qam16_count got=%0d want=2", obsq.size());
        end else begin
            total++; if (obsq[0].sym !== 6'h09 || obsq[0].nb !== 3'd4)
                begin bad++; $display("FAIL qam16_first got=%h/%0d want=09/4", obsq[0].sym, obsq[0].nb); end
            total++; if (obsq[1].sym !== 6'h06 || obsq[1].nb !== 3'd4 || obsq[1].idx !== 3'd1)
                begin bad++; $display("FAIL qam16_cfg_ignored got=%h/%0d/%0d want=06/4/1", obsq[1].sym, obsq[1].nb, obsq[1].idx); end
        end
        expq.delete(); obsq.delete();
    endtask

    task automatic test_saturate();
        drive(1'b1, 1'b1, 1'b1, 2'b11, 1024, -32768, 0);
        tick();
        drain();
        total++;
        if (obsq.size() !== 1) begin
            bad++; $display("FAIL sat_count got=%0d want=1", obsq.size());
        end else begin
            total++; if (obsq[0].sym !== 6'h18)
                begin bad++; $display("FAIL sat_symbol got=%h want=18", obsq[0].sym); end
        end
`ifdef DEMAP_OVR_CNT_EN
        total++; if (ovr_count !== 16'(m_ovr)) begin bad++; $display("FAIL ovr_count got=%0d want=%0d", ovr_count, m_ovr); end
`endif
        expq.delete(); obsq.delete();
    endtask

    task automatic test_stall();
        int iv[8], qv[8], sc, sent, pre;
        logic stalled_prev;
        beat_t snap, cur;
        sc = 21 * $urandom_range(1, 1500);
        for (int k = 0; k < 8; k++) begin iv[k] = pick_sample(sc); qv[k] = pick_sample(sc); end
        sent = 0; stalled_prev = 1'b0; snap = '0;
        for (int c = 0; c < 60 && obsq.size() < 8; c++) begin
            if (sent < 8) drive(1'b1, sent == 0, sent == 7, 2'b11, sc, iv[sent], qv[sent]);
            else drive(1'b0, 1'b0, 1'b0, 2'b11, sc, 0, 0);
            out_ready = !(c >= 3 && c <= 7);
            #1;
            cur.sym = out_symbol; cur.nb = out_nbits; cur.idx = out_sym_idx; cur.last = out_last;
            if (stalled_prev) begin
                total++; if (out_valid !== 1'b1 || cur !== snap)
                    begin bad++; $display("FAIL stall_hold c=%0d got=%h want=%h", c, cur, snap); end
            end
            if (out_valid && !out_ready) begin
                total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_in_ready c=%0d got=%b want=0", c, in_ready); end
            end
            stalled_prev = out_valid && !out_ready;
            snap = cur;
            pre = acc_cnt;
            tick();
            if (acc_cnt != pre) sent++;
        end
        drain();
        total++; if (obsq.size() !== 8) begin bad++; $display("FAIL stall_count got=%0d want=8", obsq.size()); end
        for (int k = 0; k < obsq.size() && k < expq.size(); k++) begin
            total++;
            if (obsq[k] !== expq[k] || obsq[k].idx !== IDX_W'(k) || obsq[k].last !== (k == 7)) begin
                bad++; $display("FAIL stall_beat k=%0d got=%h want=%h", k, obsq[k], expq[k]);
            end
        end
        expq.delete(); obsq.delete();
    endtask

    task automatic test_wrap_and_single();
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, k == 0, k == 9, 2'b01, 500, pick_sample(500), pick_sample(500));
            tick();
        end
        drive(1'b1, 1'b1, 1'b1, 2'b10, 300, -50, 400);
        tick();
        drain();
        total++; if (obsq.size() !== 11) begin bad++; $display("FAIL wrap_count got=%0d want=11", obsq.size()); end
        for (int k = 0; k < obsq.size() && k < expq.size(); k++) begin
            total++;
            if (obsq[k] !== expq[k] || obsq[k].idx !== IDX_W'((k < 10) ? k % 8 : 0)
                || obsq[k].last !== (k == 9 || k == 10)) begin
                bad++; $display("FAIL wrap_beat k=%0d got=%h want=%h", k, obsq[k], expq[k]);
            end
        end
        expq.delete(); obsq.delete();
    endtask

    task automatic test_random_frames();
        int lens[6] = '{10, 1, 5, 12, 3, 7};
        int sc, pre, k, iv, qv;
        logic [1:0] mode;
        for (int f = 0; f < 6; f++) begin
            sc   = (f == 2) ? 0 : 21 * $urandom_range(1, 1500);
            mode = 2'($urandom_range(0, 3));
            k = 0; iv = pick_sample(sc); qv = pick_sample(sc);
            for (int c = 0; c < 200 && k < lens[f]; c++) begin
                if (k == 0) drive($urandom_range(0, 9) < 7, 1'b1, lens[f] == 1, mode, sc, iv, qv);
                else drive($urandom_range(0, 9) < 7, 1'b0, k == lens[f] - 1, 2'($urandom_range(0, 3)),
                           int'($urandom_range(0, 32767)), iv, qv);
                out_ready = ($urandom_range(0, 9) < 7);
                pre = acc_cnt;
                tick();
                if (acc_cnt != pre) begin k++; iv = pick_sample(sc); qv = pick_sample(sc); end
            end
        end
        drain();
        total++; if (obsq.size() !== expq.size() || expq.size() !== 38)
            begin bad++; $display("FAIL rand_count got=%0d want=%0d", obsq.size(), expq.size()); end
        for (int j = 0; j < obsq.size() && j < expq.size(); j++) begin
            total++;
            if (obsq[j] !== expq[j]) begin
                bad++; $display("FAIL rand_beat j=%0d got sym=%h nb=%0d idx=%0d last=%b want sym=%h nb=%0d idx=%0d last=%b",
                                j, obsq[j].sym, obsq[j].nb, obsq[j].idx, obsq[j].last,
                                expq[j].sym, expq[j].nb, expq[j].idx, expq[j].last);
            end
        end
`ifdef DEMAP_OVR_CNT_EN
        total++; if (ovr_count !== 16'(m_ovr)) begin bad++; $display("FAIL rand_ovr got=%0d want=%0d", ovr_count, m_ovr); end
`endif
        expq.delete(); obsq.delete();
    endtask

    task automatic test_midstream_reset();
        drive(1'b1, 1'b1, 1'b0, 2'b10, 2000, 100, 200);
        tick();
        drive(1'b1, 1'b0, 1'b0, 2'b10, 2000, -100, 200);
        tick();
        drive(1'b0, 1'b0, 1'b0, 2'b10, 2000, 0, 0);
        #2;
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL midrst_pre got=%b want=1", out_valid); end
        reset = 1'b1;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_async got=%b want=0", out_valid); end
        @(negedge clk);
        reset = 1'b0;
        expq.delete(); obsq.delete();
        m_mode = 0; m_scale = 1024; m_idx = 0; m_ovr = 0;
        repeat (4) tick();
        total++; if (obsq.size() !== 0) begin bad++; $display("FAIL midrst_stale got=%0d want=0", obsq.size()); end
        drive(1'b1, 1'b0, 1'b0, 2'b11, 500, 1500, -100);
        tick();
        drain();
        total++;
        if (obsq.size() !== 1) begin
            bad++; $display("FAIL midrst_count got=%0d want=1", obsq.size());
        end else begin
            total++; if (obsq[0].sym !== 6'h01 || obsq[0].nb !== 3'd1 || obsq[0].idx !== 3'd0)
                begin bad++; $display("FAIL midrst_bpsk got=%h/%0d/%0d want=01/1/0", obsq[0].sym, obsq[0].nb, obsq[0].idx); end
        end
`ifdef DEMAP_OVR_CNT_EN
        total++; if (ovr_count !== 16'd1) begin bad++; $display("FAIL midrst_ovr got=%0d want=1", ovr_count); end
`endif
        expq.delete(); obsq.delete();
    endtask

    initial begin
        test_reset();
        test_qam64_latency();
        test_qam16_cfg_hold();
        test_saturate();
        test_stall();
        test_wrap_and_single();
        test_random_frames();
        test_midstream_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/qam_demapper_pipe.md
Name: qam_demapper_pipe

Overview:
- Parametrised, pipelined hard-decision QAM demapper for the OFDM receive chain. Sits after equalisation and before deinterleaving.
- Supports BPSK, QPSK, 16QAM and 64QAM.
- Decision thresholds scale with a runtime constellation amplitude instead of a fixed constant.
- Valid/ready streaming with frame markers. Mode and amplitude are latched per frame.

Parameters:
- DATA_W, 16, signed I/Q sample width (min 8).
- IDX_W, 12, width of the per-frame symbol index counter.
- DEFAULT_SCALE, 1024, reset value of the latched amplitude (outermost-point magnitude, DATA_W-1 bits unsigned).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- cfg_qam_type  in  2  00 BPSK, 01 QPSK, 10 16QAM, 11 64QAM; sampled on accepted in_sof beat
- cfg_scale  in  DATA_W-1  constellation amplitude; sampled on accepted in_sof beat
- in_inphase  in  DATA_W  signed I sample
- in_quadrat  in  DATA_W  signed Q sample
- in_sof  in  1  first symbol of frame
- in_last  in  1  last symbol of frame
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid & in_ready
- out_symbol  out  6  demapped bits, unused MSBs zero
- out_nbits  out  3  valid bit count: 1, 2, 4 or 6
- out_sym_idx  out  IDX_W  symbol index within frame
- out_last  out  1  propagated in_last
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream ready

Behaviour:
- Reset is asynchronous and active-high. It clears all pipeline valids and the index counter.
  - Latched mode resets to BPSK; latched scale resets to DEFAULT_SCALE.
  - Outputs at reset: out_valid=0, out_symbol=0, out_nbits=1, out_sym_idx=0, out_last=0.
  - in_ready=1 after reset.
  - Reset mid-frame discards all in-flight beats; no partial output is produced.
- Pipeline: 2 register stages. Latency is 2 cycles from accepted input to out_valid, with out_ready held high.
  - Global advance enable en = out_ready | ~out_valid.
  - in_ready = en. The whole pipe stalls while out_valid & ~out_ready.
  - Under stall, all output fields are held stable. No beat is lost or duplicated, and order is preserved.
  - Stage-1 bubbles are allowed: stage valids propagate with en.
- Stage 1 (on accept):
  - Register signs of I/Q.
  - Register magnitudes |I| and |Q|, DATA_W-1 bits. The most-negative sample saturates to 2^(DATA_W-1)-1.
  - Register the mode, scale, last and index in force for this beat.
  - If in_sof: latch cfg_qam_type and cfg_scale, and the beat uses the new values.
  - cfg_* changes mid-frame are ignored.
  - Index counter: sof beat gets index 0; each later accepted beat gets the previous index + 1.
  - The index wraps modulo 2^IDX_W.
  - in_sof & in_last on the same beat = one-symbol frame. The counter restarts on the next sof.
  - Beats without any prior sof use the reset mode/scale. The index simply counts.
- Stage 2: exact threshold compares with no division. Let S = scale. Compare constant multiples: 3|x| against 2S; 7|x| against 2S, 4S and 6S. Compare width is DATA_W+2 bits. Sign bits below are taken from the registered stage-1 signs.
  - BPSK: bit0 = ~signI.
  - QPSK: bit0 = ~signI, bit1 = ~signQ.
  - 16QAM:
    - bit0 = ~signI
    - bit1 = (3|I| < 2S)
    - bit2 = ~signQ
    - bit3 = (3|Q| < 2S)
  - 64QAM:
    - bit0 = ~signI
    - bit1 = (7|I| < 4S)
    - bit2 = (7|I| > 2S) & (7|I| < 6S)
    - bit3 = ~signQ
    - bit4 = (7|Q| < 4S)
    - bit5 = (7|Q| > 2S) & (7|Q| < 6S)
  - A sample of exactly 0 gives sign bit 1. Equality at a threshold resolves to the "not less"/"not greater" side.
  - S=0 is legal: all magnitude compares yield their strict-inequality result.

Optional Feature:
- Macro DEMAP_OVR_CNT_EN.
- When defined:
  - Adds output port ovr_count, 16 bits.
  - It counts accepted beats where |I| > S or |Q| > S, using the latched S for that beat.
  - The count is independent of mode, saturates at 65535, and clears only on reset.
- When not defined: the port and its logic are absent, and all other behaviour is identical.

Test Plan:
- Reset mid-stream with 2 beats in flight -> out_valid=0 immediately (async). No stale output after release; mode=BPSK, scale=1024.
- sof, 64QAM, S=1024, I=+300, Q=-700, out_ready=1 -> 2 cycles later out_symbol=0x27, out_nbits=6, out_sym_idx=0.
- sof, 16QAM, S=900, I=700, Q=-200 -> out_symbol=0x09, out_nbits=4. A following beat with cfg_qam_type=11 but no sof still decodes as 16QAM, idx=1.
- 64QAM, S=1024, I=-32768 -> magnitude saturates to 32767, bits[2:0]=000. With DEMAP_OVR_CNT_EN defined, ovr_count increments by 1.
- Stream 8 beats, out_ready low for cycles 3-7 -> in_ready low while stalled, outputs held stable. All 8 appear in order, idx 0..7, out_last only on beat 8.
- IDX_W=3, a 10-beat frame -> idx sequence 0..7,0,1. A single-beat frame with sof & last together -> idx=0, out_last=1.
